input_debouncer: RTL and testbench

Multi-channel input conditioner feeding the team's D flip-flop storage stage. Each channel takes an asynchronous raw level from a switch or pin, synchronizes it through a two-flop chain, and filters bounce with a per-channel stability counter and FSM. It emits a clean level plus single-cycle edge pulses, so downstream registers capture only settled data.

---
 rtl/debounce_pkg.sv | 21 ++
 rtl/debounce_channel.sv | 146 ++++++++++++++
 rtl/input_debouncer.sv | 38 +++
 tb/tb_input_debouncer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared FSM state type, limits and counter sizing for the input debouncer
package debounce_pkg;

  // Per-channel filter states; db_out is high in S_HIGH and S_FALL_WAIT
  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_RISE_WAIT = 2'd1,
    S_HIGH      = 2'd2,
    S_FALL_WAIT = 2'd3
  } db_state_e;

  localparam int DB_MIN_STABLE = 2;
  localparam int DB_MAX_STABLE = 65535;
  localparam int DB_MAX_WIDTH  = 32;

  // The counter only has to hold 0..STABLE_CYCLES-1
  function automatic int db_cnt_width(input int stable_cycles);
    return $clog2(stable_cycles);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one debounce channel: 2-flop sync, stability counter, FSM, pulse regs; DEBOUNCE_FALL_PULSE_EN builds the fall pulse
module debounce_channel #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db,
  output logic rise,
  output logic fall
);
  import debounce_pkg::*;

  localparam int CNT_W = db_cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1;
  logic             sync2;
  db_state_e        state;
  db_state_e        state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             db_q;
  logic             db_next;
  logic             rise_q;
  logic             rise_next;
`ifdef DEBOUNCE_FALL_PULSE_EN
  logic             fall_q;
  logic             fall_next;
`endif

  // Two-flop synchronizer; only sync2 is trusted by the filter
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Next-state logic: a WAIT state counts matching samples, any sample equal to db restarts
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    db_next    = db_q;
    rise_next  = 1'b0;
`ifdef DEBOUNCE_FALL_PULSE_EN
    fall_next  = 1'b0;
`endif
    case (state)
      S_LOW: begin
        if (sync2) begin
          state_next = S_RISE_WAIT;
          cnt_next   = CNT_ONE;
        end else begin
          cnt_next   = '0;
        end
      end
      S_RISE_WAIT: begin
        if (!sync2) begin
          state_next = S_LOW;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = S_HIGH;
          cnt_next   = '0;
          db_next    = 1'b1;
          rise_next  = 1'b1;
        end else begin
          cnt_next   = cnt + CNT_ONE;
        end
      end
      S_HIGH: begin
        if (!sync2) begin
          state_next = S_FALL_WAIT;
          cnt_next   = CNT_ONE;
        end else begin
          cnt_next   = '0;
        end
      end
      S_FALL_WAIT: begin
        if (sync2) begin
          state_next = S_HIGH;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = S_LOW;
          cnt_next   = '0;
          db_next    = 1'b0;
`ifdef DEBOUNCE_FALL_PULSE_EN
          fall_next  = 1'b1;
`endif
        end else begin
          cnt_next   = cnt + CNT_ONE;
        end
      end
      default: begin
        state_next = S_LOW;
        cnt_next   = '0;
        db_next    = 1'b0;
      end
    endcase
  end

  // FSM state and stability counter; reset discards any partial count
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_LOW;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Registered level and edge pulses so downstream sees glitch-free flops
  always_ff @(posedge clk) begin
    if (rst) begin
      db_q   <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      db_q   <= db_next;
      rise_q <= rise_next;
    end
  end

`ifdef DEBOUNCE_FALL_PULSE_EN
  // Falling-edge pulse register, only present when fall pulses are wanted
  always_ff @(posedge clk) begin
    if (rst) begin
      fall_q <= 1'b0;
    end else begin
      fall_q <= fall_next;
    end
  end

  assign fall = fall_q;
`else
  assign fall = 1'b0;
`endif

  assign db   = db_q;
  assign rise = rise_q;

endmodule

// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - multi-channel input debouncer top; DEBOUNCE_FALL_PULSE_EN enables fall_pulse generation
module input_debouncer #(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] db_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);
  import debounce_pkg::*;

  if (WIDTH < 1 || WIDTH > DB_MAX_WIDTH) begin : g_bad_width
    $error("input_debouncer: WIDTH=%0d outside 1..%0d", WIDTH, DB_MAX_WIDTH);
  end

  if (STABLE_CYCLES < DB_MIN_STABLE || STABLE_CYCLES > DB_MAX_STABLE) begin : g_bad_stable
    $error("input_debouncer: STABLE_CYCLES=%0d outside %0d..%0d",
           STABLE_CYCLES, DB_MIN_STABLE, DB_MAX_STABLE);
  end

  // Channels share nothing but clock and reset
  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_chan (
      .clk  (clk),
      .rst  (rst),
      .raw  (raw_in[i]),
      .db   (db_out[i]),
      .rise (rise_pulse[i]),
      .fall (fall_pulse[i])
    );
  end

endmodule

// File: tb/tb_input_debouncer.sv
// tb/tb_input_debouncer.sv - self-checking bench for input_debouncer against a run-length reference model
module tb_input_debouncer;
  localparam int W = 4;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] raw_in = '0;
  logic [W-1:0] db_out;
  logic [W-1:0] rise_pulse;
  logic [W-1:0] fall_pulse;

  int checks = 0;
  int errors = 0;

  // Reference model: two-sample delay line, then the output flips once
  // N consecutive delayed samples disagree with it
  logic [W-1:0] m_d1 = '0;
  logic [W-1:0] m_d2 = '0;
  logic [W-1:0] m_out = '0;
  logic [W-1:0] m_rise = '0;
  logic [W-1:0] m_fall = '0;
  int           m_run [W];

  input_debouncer #(.WIDTH(W), .STABLE_CYCLES(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .raw_in     (raw_in),
    .db_out     (db_out),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] exp_fall();
`ifdef DEBOUNCE_FALL_PULSE_EN
    return m_fall;
`else
    return '0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    for (int i = 0; i < W; i++) begin
      logic smp;
      if (rst) begin
        m_d1[i] = 1'b0; m_d2[i] = 1'b0; m_out[i] = 1'b0;
        m_rise[i] = 1'b0; m_fall[i] = 1'b0; m_run[i] = 0;
      end else begin
        smp = m_d2[i];
        m_d2[i] = m_d1[i];
        m_d1[i] = raw_in[i];
        m_rise[i] = 1'b0;
        m_fall[i] = 1'b0;
        if (smp != m_out[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == N) begin
            m_out[i] = smp;
            m_run[i] = 0;
            if (smp) m_rise[i] = 1'b1;
            else     m_fall[i] = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
    #1;
  endtask

  task automatic apply_reset(input logic [W-1:0] r);
    raw_in = r;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    raw_in = 4'hF;
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if ({db_out, rise_pulse, fall_pulse} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs got db=%h rise=%h fall=%h want all 0", db_out, rise_pulse, fall_pulse);
    end
    rst = 1'b0;
    n = 0;
    while (db_out !== 4'hF && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (n !== N + 2) begin
      errors++;
      $display("FAIL reset_release_latency got %0d edges want %0d", n, N + 2);
    end
    checks++;
    if (rise_pulse !== 4'hF) begin
      errors++;
      $display("FAIL reset_release_rise got %h want f", rise_pulse);
    end
    step();
    checks++;
    if (rise_pulse !== 4'h0 || db_out !== 4'hF) begin
      errors++;
      $display("FAIL reset_release_after got rise=%h db=%h want rise=0 db=f", rise_pulse, db_out);
    end
  endtask

  task automatic test_clean_rise();
    int n;
    apply_reset(4'h0);
    step();
    step();
    raw_in[0] = 1'b1;
    n = 0;
    while (db_out[0] !== 1'b1 && n < 20) begin
      step();
      n++;
      checks++;
      if (db_out !== m_out || rise_pulse !== m_rise) begin
        errors++;
        $display("FAIL clean_rise_model got db=%h rise=%h want db=%h rise=%h", db_out, rise_pulse, m_out, m_rise);
      end
    end
    checks++;
    if (n !== N + 2 || rise_pulse !== 4'b0001) begin
      errors++;
      $display("FAIL clean_rise_latency got %0d edges rise=%h want %0d edges rise=1", n, rise_pulse, N + 2);
    end
    step();
    checks++;
    if (rise_pulse[0] !== 1'b0 || db_out[0] !== 1'b1) begin
      errors++;
      $display("FAIL clean_rise_pulse_width got rise0=%b db0=%b want 0 1", rise_pulse[0], db_out[0]);
    end
  endtask

  task automatic test_bounce();
    int n;
    apply_reset(4'h0);
    for (int b = 0; b < 4; b++) begin
      raw_in[1] = (b % 2 == 0);
      repeat (2) begin
        step();
        checks++;
        if (rise_pulse[1] !== 1'b0 || db_out[1] !== 1'b0 || db_out !== m_out) begin
          errors++;
          $display("FAIL bounce_no_pulse got rise1=%b db=%h want 0 db=%h", rise_pulse[1], db_out, m_out);
        end
      end
    end
    raw_in[1] = 1'b1;
    n = 0;
    while (db_out[1] !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (n !== N + 2 || rise_pulse[1] !== 1'b1) begin
      errors++;
      $display("FAIL bounce_settle got %0d edges rise1=%b want %0d edges rise1=1", n, rise_pulse[1], N + 2);
    end
  endtask

  task automatic test_fall();
    int n;
    logic want_fall;
`ifdef DEBOUNCE_FALL_PULSE_EN
    want_fall = 1'b1;
`else
    want_fall = 1'b0;
`endif
    apply_reset(4'b0100);
    repeat (8) step();
    checks++;
    if (db_out !== 4'b0100) begin
      errors++;
      $display("FAIL fall_setup got db=%h want 4", db_out);
    end
    raw_in[2] = 1'b0;
    n = 0;
    while (db_out[2] !== 1'b0 && n < 20) begin
      step();
      n++;
      checks++;
      if (fall_pulse !== exp_fall() || rise_pulse !== m_rise) begin
        errors++;
        $display("FAIL fall_model got fall=%h rise=%h want fall=%h rise=%h", fall_pulse, rise_pulse, exp_fall(), m_rise);
      end
    end
    checks++;
    if (n !== N + 2 || fall_pulse[2] !== want_fall) begin
      errors++;
      $display("FAIL fall_latency got %0d edges fall2=%b want %0d edges fall2=%b", n, fall_pulse[2], N + 2, want_fall);
    end
    step();
    checks++;
    if (fall_pulse !== 4'h0 || db_out[2] !== 1'b0) begin
      errors++;
      $display("FAIL fall_pulse_width got fall=%h db2=%b want 0 0", fall_pulse, db_out[2]);
    end
  endtask

  task automatic test_independence();
    apply_reset(4'h0);
    raw_in[0] = 1'b1;
    raw_in[3] = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      raw_in[1] = (((n - 1) / 2) % 2 == 0);
      step();
      checks++;
      if (rise_pulse !== ((n == N + 2) ? 4'b1001 : 4'b0000) || db_out[1] !== 1'b0) begin
        errors++;
        $display("FAIL independence edge %0d got rise=%h db=%h want rise=%h db1=0", n, rise_pulse, db_out,
                 (n == N + 2) ? 4'b1001 : 4'b0000);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    int n;
    apply_reset(4'h0);
    raw_in[0] = 1'b1;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (db_out[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_clear got db0=%b want 0", db_out[0]);
    end
    n = 0;
    while (db_out[0] !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (n !== N + 2) begin
      errors++;
      $display("FAIL mid_reset_latency got %0d edges want %0d", n, N + 2);
    end
  endtask

  task automatic test_random();
    int hold [W];
    apply_reset(4'h0);
    for (int i = 0; i < W; i++) hold[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < W; i++) begin
        if (hold[i] == 0) begin
          raw_in[i] = 1'($urandom_range(0, 1));
          hold[i] = $urandom_range(1, 7);
        end
        hold[i]--;
      end
      rst = ($urandom_range(0, 299) == 0);
      step();
      checks++;
      if (db_out !== m_out || rise_pulse !== m_rise || fall_pulse !== exp_fall()) begin
        errors++;
        $display("FAIL random cycle %0d got db=%h rise=%h fall=%h want db=%h rise=%h fall=%h",
                 c, db_out, rise_pulse, fall_pulse, m_out, m_rise, exp_fall());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < W; i++) m_run[i] = 0;
    test_reset();
    test_clean_rise();
    test_bounce();
    test_fall();
    test_independence();
    test_reset_mid_count();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
